ifetch: RTL and testbench

Instruction-fetch stage of the five-stage RV64 pipeline. Holds the program counter, issues one instruction-bus request at a time, and presents each fetched instruction to decode as a registered `fetch_data_t`. Handles decode back-pressure (`stall`) and control-flow redirects from execute. A request already outstanding on the bus cannot be cancelled, so its response is discarded.

---
 rtl/common_pkg.sv | 7 +
 rtl/pipes_pkg.sv | 19 +
 rtl/pcselect.sv | 21 ++
 rtl/ifetch.sv | 123 ++++++++++++
 tb/tb_ifetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared constants for the RV64 pipeline.
package common;

    // First instruction address after reset.
    localparam logic [63:0] PC_RESET = 64'h8000_0000;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage payload types and the fetch-stage state encoding.
package pipes;

    // Fetch -> decode payload.
    typedef struct packed {
        logic        valid;
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_data_t;

    // Word parked while decode is stalled; validity is implied by the HOLD state.
    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_buf_t;

    typedef enum logic [1:0] {F_FETCH, F_HOLD, F_DISCARD} fetch_state_t;

endpackage

// File: rtl/pcselect.sv
// Next-PC mux for the fetch stage: redirect, sequential advance, or hold.
module pcselect (
    input  logic [63:0] pc_q,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        advance,
    output logic [63:0] pc_d
);

    // Redirect wins; the target is forced to word alignment.
    always_comb begin
        if (redirect_valid) begin
            pc_d = redirect_pc & ~64'd3;
        end else if (advance) begin
            pc_d = pc_q + 64'd4;
        end else begin
            pc_d = pc_q;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: one outstanding bus request, one-deep stall buffer,
// and discard of a request orphaned by a redirect.
module ifetch
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = common::PC_RESET
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  disc_addr_q, disc_addr_d;
    fetch_buf_t   buf_q, buf_d;
    fetch_data_t  out_q, out_d;

    logic         advance;
    logic         deliver;
    fetch_data_t  deliver_data;

    pcselect u_pcselect (
        .pc_q           (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc_d           (pc_d)
    );

    // Request side: HOLD issues nothing, DISCARD keeps the orphaned address on the bus.
    always_comb begin
        ireq_valid = resetn && (state_q != F_HOLD);
        ireq_addr  = (state_q == F_DISCARD) ? disc_addr_q : pc_q;
    end

    // Next-state, buffer and output-register update.
    always_comb begin
        state_d      = state_q;
        disc_addr_d  = disc_addr_q;
        buf_d        = buf_q;
        advance      = 1'b0;
        deliver      = 1'b0;
        deliver_data = out_q;

        unique case (state_q)
            F_FETCH: begin
                if (iresp_data_ok) begin
                    // A word returned alongside a redirect is simply dropped.
                    if (!redirect_valid) begin
                        advance = 1'b1;
                        if (stall) begin
                            buf_d   = '{raw_instr: iresp_data, pc: pc_q};
                            state_d = F_HOLD;
                        end else begin
                            deliver      = 1'b1;
                            deliver_data = '{valid: 1'b1, raw_instr: iresp_data, pc: pc_q};
                        end
                    end
                end else if (redirect_valid) begin
                    // The in-flight request cannot be cancelled; remember it to drain it.
                    disc_addr_d = pc_q;
                    state_d     = F_DISCARD;
                end
            end
            F_HOLD: begin
                if (redirect_valid) begin
                    state_d = F_FETCH;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_data = '{valid: 1'b1, raw_instr: buf_q.raw_instr, pc: buf_q.pc};
                    state_d      = F_FETCH;
                end
            end
            F_DISCARD: begin
                if (iresp_data_ok) begin
                    state_d = F_FETCH;
                end
            end
            default: begin
                state_d = F_FETCH;
            end
        endcase

        out_d = out_q;
        if (redirect_valid) begin
            out_d.valid = 1'b0;
        end else if (stall) begin
            out_d = out_q;
        end else if (deliver) begin
            out_d = deliver_data;
        end else begin
            out_d.valid = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= F_FETCH;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
            buf_q       <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            buf_q       <= buf_d;
            out_q       <= out_d;
        end
    end

    assign dataF = out_q;

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a bus responder with random latency, a
// transaction-level model of which words must reach decode, and a monitor
// that pops that expectation queue whenever decode accepts an instruction.
module tb_ifetch;
    import pipes::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          NCYC   = 3000;

    logic        clk;
    logic        resetn;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    // Words that decode must still receive, in program order.
    exp_t        exp_q[$];
    // Reference state: address of the next new request, the request on the bus,
    // whether it was orphaned by a redirect, and whether a stalled word is parked.
    logic [63:0] exp_addr;
    logic [63:0] req_addr;
    bit          pending;
    bit          orphan;
    bit          holding;
    int          lat;
    bit          active;
    bit          deliver_now;

    task automatic model_reset();
        exp_q.delete();
        exp_addr    = RST_PC;
        pending     = 0;
        orphan      = 0;
        holding     = 0;
        lat         = 0;
        deliver_now = 0;
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        if ($urandom_range(0, 3) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        else t = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 1023))};
        return t;
    endfunction

    // One bus/decode stimulus cycle, driven just after the rising edge.
    task automatic drive_cycle(input bit quiet, input bit bus_off);
        bit          st, rd, dok;
        logic [63:0] rpc;
        if (iresp_data_ok) pending = 0;

        chk("ireq_valid", 64'(ireq_valid), 64'(!holding));
        if (ireq_valid) begin
            if (!pending) begin
                chk("ireq_addr_new", ireq_addr, exp_addr);
                pending  = 1;
                orphan   = 0;
                req_addr = exp_addr;
                lat      = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            end else begin
                chk("ireq_addr_stable", ireq_addr, req_addr);
            end
        end

        st  = !quiet && ($urandom_range(0, 99) < 30);
        rd  = !quiet && ($urandom_range(0, 99) < 8);
        rpc = pick_target();
        dok = 0;
        if (pending && !bus_off) begin
            if (lat == 0) dok = 1;
            else lat--;
        end

        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rd ? rpc : 64'($urandom);
        iresp_data_ok  = dok;
        iresp_data     = dok ? mem_word(req_addr) : 32'($urandom);

        deliver_now = 0;
        if (holding && (rd || !st)) holding = 0;
        if (dok && !orphan && !rd) begin
            exp_q.push_back('{pc: req_addr, word: mem_word(req_addr)});
            if (st) holding = 1;
            else deliver_now = 1;
        end
        if (pending && !dok && rd) orphan = 1;
        if (rd) begin
            exp_q.delete();
            exp_addr = rpc & ~64'd3;
        end else if (dok && !orphan) begin
            exp_addr = req_addr + 64'd4;
        end
    endtask

    // Monitor: pops an expectation whenever decode accepts dataF.
    bit exp_valid_next = 0;
    bit exp_bubble_next = 0;
    always @(negedge clk) begin
        if (!resetn || !active) begin
            exp_valid_next  = 0;
            exp_bubble_next = 0;
        end else begin
            if (exp_bubble_next) chk("bubble_after_redirect", 64'(dataF.valid), 64'd0);
            if (exp_valid_next) chk("valid_latency", 64'(dataF.valid), 64'd1);
            if (dataF.valid && !stall && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dataF_pc", dataF.pc, e.pc);
                    chk("dataF_instr", 64'(dataF.raw_instr), 64'(e.word));
                end
            end
            exp_bubble_next = redirect_valid;
            exp_valid_next  = deliver_now;
        end
    end

    task automatic quiet_inputs();
        stall          = 0;
        redirect_valid = 0;
        redirect_pc    = '0;
        iresp_data_ok  = 0;
        iresp_data     = '0;
    endtask

    initial begin
        active = 0;
        resetn = 0;
        quiet_inputs();
        model_reset();
        #1;
        chk("reset_dataF", 64'(dataF), 64'd0);
        chk("reset_ireq_valid", 64'(ireq_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1;
        #1;
        chk("first_req_valid", 64'(ireq_valid), 64'd1);
        chk("first_req_addr", ireq_addr, RST_PC);
        active = 1;

        for (int c = 0; c < NCYC; c++) begin
            if (c == NCYC / 2) begin
                // Asynchronous reset in the middle of a cycle, likely mid-request.
                @(posedge clk);
                #3 resetn = 0;
                active = 0;
                #1;
                chk("async_reset_dataF", 64'(dataF), 64'd0);
                chk("async_reset_ireq_valid", 64'(ireq_valid), 64'd0);
                quiet_inputs();
                @(posedge clk);
                #3 resetn = 1;
                model_reset();
                active = 1;
            end
            @(posedge clk);
            #1;
            drive_cycle(c >= NCYC - 30, c >= NCYC - 8);
        end
        @(posedge clk);
        #1;
        quiet_inputs();
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
